spi_eeprom_prefetch: RTL and testbench

Upstream fetch stage for the VSLC core: an SPI mode-0 master that reads a 25xx-series serial EEPROM with the READ command (0x03) and an 8-bit start address, then streams program bytes into a small FIFO. The core pops them over a valid/ready byte interface. It replaces per-bit EEPROM handling in the executer, so instruction execution and SPI shifting decouple. Backpressure stretches SCK between bytes, never inside one.

---
 rtl/vslc_spi_pkg.sv | 19 +
 rtl/byte_fifo.sv | 61 ++++++
 rtl/spi_eeprom_prefetch.sv | 201 ++++++++++++++++++++
 tb/tb_spi_eeprom_prefetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_spi_pkg.sv
// Shared types and constants for the SPI EEPROM prefetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vslc_spi_pkg;

  localparam int ADDR_W = 8;
  localparam logic [7:0] EEPROM_READ_CMD = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CMD,
    ADDR,
    DATA,
    PAUSE,
    DESELECT
  } state_e;

endpackage

// File: rtl/byte_fifo.sv
// Small circular FIFO holding {data, addr} words for the prefetch stage.
// Latency: a push is visible at the head one cycle later; a pop advances the head next cycle.
// Backpressure: push dropped when full unless popped in the same cycle; flush beats push and pop.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         head_vld_o,
  output logic [AW:0]  count_o
);

  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic          vld_q;
  logic          full, push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i & vld_q & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full | pop_ok);
  assign count_d = flush_i ? '0 : (count_q + CW'(push_ok) - CW'(pop_ok));

  assign head_dat_o = mem_q[rd_q];
  assign head_vld_o = vld_q;
  assign count_o    = count_q;

  // Storage, pointers and a registered non-empty flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      vld_q   <= (count_d != '0);
      if (flush_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push_ok) begin
          mem_q[wr_q] <= push_dat_i;
          wr_q        <= wr_q + AW'(1);
        end
        if (pop_ok) rd_q <= rd_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_eeprom_prefetch.sv
// SPI mode-0 master streaming a 25xx EEPROM (READ 0x03 + 8-bit address) into a byte FIFO.
// Latency: cs_n falls 1 cycle after start; first byte_valid at 4+47*SCK_HALF cycles.
// Backpressure: when the FIFO would overflow, SCK parks low between bytes (never mid-byte).
module spi_eeprom_prefetch
  import vslc_spi_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SCK_HALF = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic [7:0]        byte_data,
  output logic [ADDR_W-1:0] byte_addr,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_copi,
  input  logic              spi_cipo
);

  localparam int DSEL = (SCK_HALF > 2) ? SCK_HALF : 2;
  localparam int DW   = $clog2(DSEL + 1);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] HALF_END = DW'(SCK_HALF - 1);
  localparam logic [DW-1:0] DSEL_END = DW'(DSEL - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  state_e            state_q;
  logic [DW-1:0]     div_q;
  logic [2:0]        bit_q;
  logic              sck_q, sck_prev_q, cs_n_q, busy_q, restart_q;
  logic [15:0]       tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [6:0]        rx_q;
  logic              cipo_s1_q, cipo_s2_q;
  logic [1:0]        cap_q, last_q;
  logic              flush, push, room, sample;
  logic [7:0]        push_byte;
  logic [CW-1:0]     fifo_count;
  logic [15:0]       head_dat;

  // Any start or stop discards buffered bytes and whatever is still in flight.
  assign flush     = start | stop;
  // Rising SCK of a data bit; cipo for it reaches cipo_s2_q two cycles later.
  assign sample    = sck_q & ~sck_prev_q & (state_q == DATA);
  assign push      = cap_q[1] & last_q[1];
  assign push_byte = {rx_q, cipo_s2_q};
  // A byte whose last bit is still in the synchroniser counts as already occupying a slot.
  assign room      = ({1'b0, fifo_count} + {{CW{1'b0}}, |last_q}) < (CW + 1)'(DEPTH);

  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_copi  = tx_q[15];
  assign busy      = busy_q;
  assign byte_data = head_dat[15:8];
  assign byte_addr = head_dat[7:0];

  // Synchronise cipo and carry rise strobes down the 2-cycle pipeline to the shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_s1_q  <= 1'b0;
      cipo_s2_q  <= 1'b0;
      sck_prev_q <= 1'b0;
      cap_q      <= '0;
      last_q     <= '0;
      rx_q       <= '0;
    end else begin
      cipo_s1_q  <= spi_cipo;
      cipo_s2_q  <= cipo_s1_q;
      sck_prev_q <= sck_q;
      if (flush) begin
        cap_q  <= '0;
        last_q <= '0;
      end else begin
        cap_q  <= {cap_q[0], sample};
        last_q <= {last_q[0], sample & (bit_q == 3'd7)};
      end
      if (cap_q[1]) rx_q <= push_byte[6:0];
    end
  end

  // Stream sequencer: chip select, SCK divider, bit counter and command/address shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      restart_q <= 1'b0;
      tx_q      <= '0;
      addr_q    <= '0;
    end else begin
      if (push) addr_q <= addr_q + 8'd1;
      if (start && state_q == IDLE) begin
        state_q <= SELECT;
        cs_n_q  <= 1'b0;
        div_q   <= '0;
        tx_q    <= {EEPROM_READ_CMD, start_addr};
        addr_q  <= start_addr;
        busy_q  <= 1'b1;
      end else if ((start || stop) && state_q != IDLE) begin
        // Abort: deselect immediately; a start re-enters SELECT after the gap.
        state_q   <= DESELECT;
        cs_n_q    <= 1'b1;
        sck_q     <= 1'b0;
        div_q     <= '0;
        tx_q      <= '0;
        restart_q <= start;
        busy_q    <= start;
        if (start) addr_q <= start_addr;
      end else begin
        case (state_q)
          IDLE: ;
          SELECT: begin
            if (div_q == HALF_END) begin
              div_q   <= '0;
              sck_q   <= 1'b1;
              bit_q   <= '0;
              state_q <= CMD;
            end else begin
              div_q <= div_q + DIV_ONE;
            end
          end
          CMD, ADDR, DATA: begin
            if (div_q != HALF_END) begin
              div_q <= div_q + DIV_ONE;
            end else begin
              div_q <= '0;
              if (sck_q) begin
                sck_q <= 1'b0;
                tx_q  <= {tx_q[14:0], 1'b0};
              end else if (bit_q != 3'd7) begin
                sck_q <= 1'b1;
                bit_q <= bit_q + 3'd1;
              end else begin
                bit_q <= '0;
                if (state_q == CMD) begin
                  state_q <= ADDR;
                  sck_q   <= 1'b1;
                end else if (state_q == ADDR) begin
                  state_q <= DATA;
                  sck_q   <= 1'b1;
                end else if (room) begin
                  sck_q <= 1'b1;
                end else begin
                  state_q <= PAUSE;
                end
              end
            end
          end
          PAUSE: begin
            if (room) begin
              state_q <= DATA;
              sck_q   <= 1'b1;
              div_q   <= '0;
            end
          end
          DESELECT: begin
            if (div_q == DSEL_END) begin
              div_q     <= '0;
              restart_q <= 1'b0;
              if (restart_q) begin
                state_q <= SELECT;
                cs_n_q  <= 1'b0;
                tx_q    <= {EEPROM_READ_CMD, addr_q};
              end else begin
                state_q <= IDLE;
              end
            end else begin
              div_q <= div_q + DIV_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  byte_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .push_i     (push),
    .push_dat_i ({push_byte, addr_q}),
    .pop_i      (byte_ready),
    .head_dat_o (head_dat),
    .head_vld_o (byte_valid),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_spi_eeprom_prefetch.sv
// Directed bench for spi_eeprom_prefetch with a behavioural 25xx EEPROM.
// Latency: n/a.
// Backpressure: exercised via byte_ready.
module tb_spi_eeprom_prefetch;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, byte_ready, spi_cipo;
  logic [7:0] start_addr, byte_data, byte_addr;
  logic       byte_valid, busy, spi_cs_n, spi_sck, spi_copi;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spi_eeprom_prefetch #(.DEPTH(4), .SCK_HALF(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .byte_data  (byte_data),
    .byte_addr  (byte_addr),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_copi   (spi_copi),
    .spi_cipo   (spi_cipo)
  );

  // EEPROM contents: 0xA5, 0x3C at 0x00/0x01, then (a ^ 0x5A) + 3.
  function automatic logic [7:0] eep(input logic [7:0] a);
    if (a == 8'h00) return 8'hA5;
    if (a == 8'h01) return 8'h3C;
    return (a ^ 8'h5A) + 8'd3;
  endfunction

  int         m_bits   = 0;
  int         cs_falls = 0;
  logic [15:0] m_sh    = '0;
  logic [7:0]  m_cmd   = '0;
  logic [7:0]  m_addr  = '0;

  initial spi_cipo = 1'b0;

  always @(negedge spi_cs_n) begin
    m_bits = 0;
    cs_falls++;
  end

  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      if (m_bits < 16) m_sh = {m_sh[14:0], spi_copi};
      m_bits++;
      if (m_bits == 16) begin
        m_cmd  = m_sh[15:8];
        m_addr = m_sh[7:0];
      end
    end
  end

  always @(negedge spi_sck) begin : eep_out
    int         j;
    logic [7:0] a, b;
    if (!spi_cs_n && m_bits >= 16) begin
      j = m_bits - 16;
      a = m_addr + 8'(j / 8);
      b = eep(a);
      #2 spi_cipo = b[7 - (j % 8)];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic with_stop);
    start      = 1'b1;
    start_addr = a;
    stop       = with_stop;
    tick();
    start      = 1'b0;
    stop       = 1'b0;
    start_addr = 8'h99;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (5) tick();
  endtask

  task automatic wait_bits(input int n, input string name);
    int k = 0;
    while (m_bits < n && k < 2000) begin
      tick();
      k++;
    end
    check(name, 32'(m_bits >= n), 1);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!byte_valid && k < 400) begin
      tick();
      k++;
    end
    check(name, 32'(byte_valid), 1);
  endtask

  typedef struct {
    logic [7:0]  saddr;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int         cyc, hi, n, k, fall0;
    logic [7:0] got_d [4];
    logic [7:0] got_a [4];

    vecs[0] = '{8'h00, 32'h00_01_02_03, 32'hA5_3C_5B_5C};
    vecs[1] = '{8'hFE, 32'hFE_FF_00_01, 32'hA7_A8_A5_3C};
    vecs[2] = '{8'h40, 32'h40_41_42_43, 32'h1D_1E_1B_1C};
    vecs[3] = '{8'h7F, 32'h7F_80_81_82, 32'h28_DD_DE_DB};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; start_addr = '0; byte_ready = 1'b0;
    repeat (3) tick();
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_copi", spi_copi, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data_addr", {byte_data, byte_addr}, 16'h0000);
    rst_n = 1'b1;
    tick();

    // First-byte latency and command/address framing
    pulse_start(8'h00, 1'b0);
    check("cs_low_cycle1", spi_cs_n, 0);
    cyc = 1;
    while (!byte_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    check("first_valid_cycle", cyc, 51);
    check("first_data", byte_data, 8'hA5);
    check("first_addr", byte_addr, 8'h00);
    check("cmd_seen", m_cmd, 8'h03);
    check("addr_seen", m_addr, 8'h00);

    // Backpressure: exactly DEPTH bytes, SCK parked low with cs_n low
    repeat (300) tick();
    check("full_sck_rises", m_bits, 48);
    check("full_sck_low", spi_sck, 0);
    check("full_cs_low", spi_cs_n, 0);
    check("full_busy", busy, 1);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    check("pop_head", {byte_data, byte_addr}, 16'h3C01);
    repeat (100) tick();
    check("one_more_burst", m_bits, 56);
    check("reparked_sck", spi_sck, 0);

    // stop during PAUSE
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_cs_n", spi_cs_n, 1);
    check("stop_busy", busy, 0);
    check("stop_valid", byte_valid, 0);
    repeat (5) tick();

    // start and stop together mid-stream: start wins
    pulse_start(8'h00, 1'b0);
    wait_bits(20, "pre_restart_bits");
    pulse_start(8'h10, 1'b1);
    check("startstop_busy", busy, 1);
    k = 0;
    while (spi_cs_n && k < 50) begin
      tick();
      k++;
    end
    wait_bits(16, "startstop_bits");
    check("startstop_addr", m_addr, 8'h10);
    byte_ready = 1'b1;
    wait_valid("startstop_valid");
    check("startstop_head", {byte_data, byte_addr}, 16'h4D10);
    byte_ready = 1'b0;
    pulse_stop();

    // Restart mid-byte with two bytes buffered
    pulse_start(8'h00, 1'b0);
    wait_bits(36, "midbyte_bits");
    check("two_buffered", byte_valid, 1);
    pulse_start(8'h40, 1'b0);
    check("restart_flush", byte_valid, 0);
    hi = 0;
    while (spi_cs_n && hi < 50) begin
      hi++;
      tick();
    end
    check("deselect_gap", 32'(hi >= 2 && hi < 50), 1);
    wait_bits(16, "restart_bits");
    check("restart_cmd", m_cmd, 8'h03);
    check("restart_addr", m_addr, 8'h40);
    byte_ready = 1'b1;
    wait_valid("restart_valid");
    check("restart_head", {byte_data, byte_addr}, 16'h1D40);
    byte_ready = 1'b0;
    pulse_stop();

    // Asynchronous reset during the address phase
    pulse_start(8'h00, 1'b0);
    wait_bits(12, "addr_phase_bits");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_cs_n", spi_cs_n, 1);
    check("arst_sck", spi_sck, 0);
    check("arst_copi_valid_busy", {spi_copi, byte_valid, busy}, 3'b000);
    check("arst_data_addr", {byte_data, byte_addr}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) tick();
    check("post_rst_idle_cs", spi_cs_n, 1);
    check("post_rst_idle_busy", busy, 0);

    // Table-driven streams with continuous pops
    for (int v = 0; v < 4; v++) begin
      pulse_start(vecs[v].saddr, 1'b0);
      fall0      = cs_falls;
      byte_ready = 1'b1;
      n = 0;
      k = 0;
      while (n < 4 && k < 400) begin
        if (byte_valid) begin
          got_d[n] = byte_data;
          got_a[n] = byte_addr;
          n++;
        end
        tick();
        k++;
      end
      check($sformatf("vec%0d_count", v), n, 4);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("vec%0d_dat%0d", v, i), got_d[i], vecs[v].exp_dat[31-8*i -: 8]);
        check($sformatf("vec%0d_adr%0d", v, i), got_a[i], vecs[v].exp_adr[31-8*i -: 8]);
      end
      check($sformatf("vec%0d_single_cs", v), cs_falls, fall0);
      check($sformatf("vec%0d_cmd_addr", v), {m_cmd, m_addr}, {8'h03, vecs[v].saddr});
      byte_ready = 1'b0;
      pulse_stop();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
